// File: rtl/jpeg_dma_pp.sv
// jpeg_dma_pp: Wishbone classic master that fetches BLK_W x BLK_W byte-pixel
// blocks from a raster image into a two-bank (ping-pong) DCT input BRAM and
// launches the DCT on every filled bank.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   dmaen_i, wb_adr_i,     CPU slave register port (adr[4:2] selects register,
//   wb_dat_i, wb_we_i,     read data is combinational)
//   wb_dat_o
//   wbm_*                  Wishbone master read port (always word reads)
//   bram_data_o/addr_o/we_o  DCT input BRAM write port, address {bank, word}
//   start_dct_o, dct_bank_o, dct_busy_i  DCT launch handshake
module jpeg_dma_pp #(
    parameter  int BLK_W    = 8,
    parameter  int PITCH_W  = 16,
    parameter  int BLKCNT_W = 8,
    localparam int WPB      = BLK_W * BLK_W / 4,
    localparam int BA_W     = $clog2(WPB) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dmaen_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_we_i,
    output logic [31:0]     wb_dat_o,
    output logic [31:0]     wbm_adr_o,
    input  logic [31:0]     wbm_dat_i,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [3:0]      wbm_sel_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic [31:0]     bram_data_o,
    output logic [BA_W-1:0] bram_addr_o,
    output logic            bram_we_o,
    output logic            start_dct_o,
    output logic            dct_bank_o,
    input  logic            dct_busy_i
);
    localparam int WI_W = $clog2(WPB);
    localparam int COLS = BLK_W / 4;
    localparam int BSH  = $clog2(BLK_W);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_RELEASE, S_WAITNEXT, S_WAITBANK, S_FLUSH
    } state_t;

    state_t              state_q;
    logic [31:0]         src_q;
    logic [PITCH_W-1:0]  pitch_q;
    logic [BLKCNT_W-1:0] endx_q, endy_q, bx_q, by_q;
    // Address is kept as a chain of origins: block-row, block, pixel row, word.
    logic [31:0]         yorg_q, borg_q, row_q, addr_q;
    logic [WI_W-1:0]     widx_q;
    logic                cyc_q, fill_q, auto_q, error_q, done_q, fend_q;
    logic                act_q, start_q, dbank_q, nptr_q;
    logic [1:0]          full_q;
    logic [15:0]         cnt_q;

    logic [31:0]         yorg_d, borg_d, row_d, addr_d;
    logic [BLKCNT_W-1:0] bx_d, by_d;

    logic [2:0]  sel;
    logic        reg_wr, ctrl_wr, c_start, c_next, c_abort;
    logic        col_last, blk_last, frame_last;
    logic        ack_ok, bus_err, dct_done, launch, other_bank;
    logic [1:0]  freeing, bank_free;
    logic [31:0] pitch32, pblk32, blkw32;
    logic        unused_adr;

    assign sel     = wb_adr_i[4:2];
    assign reg_wr  = dmaen_i & wb_we_i;
    assign ctrl_wr = reg_wr & (sel == 3'd4);
    assign c_start = ctrl_wr & wb_dat_i[0];
    assign c_next  = ctrl_wr & wb_dat_i[1];
    assign c_abort = ctrl_wr & wb_dat_i[3];
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign col_last   = (widx_q & WI_W'(COLS - 1)) == WI_W'(COLS - 1);
    assign blk_last   = (widx_q == WI_W'(WPB - 1));
    assign frame_last = blk_last & (bx_q == endx_q) & (by_q == endy_q);

    // An error outranks a simultaneous ack, and an abort suppresses the write too.
    assign ack_ok  = (state_q == S_FETCH) & cyc_q & wbm_ack_i & ~wbm_err_i & ~c_abort;
    assign bus_err = (state_q == S_FETCH) & cyc_q & wbm_err_i;

    // DCT completion: busy low on any cycle after the launch pulse.
    assign dct_done   = act_q & ~start_q & ~dct_busy_i;
    assign freeing    = dct_done ? (dbank_q ? 2'b10 : 2'b01) : 2'b00;
    // A bank released by the DCT this very cycle is already usable by the FSM.
    assign bank_free  = ~full_q | freeing;
    assign other_bank = ~fill_q;
    // Banks are filled strictly alternately, so a toggling pointer is the
    // oldest-first order; it restarts at bank 0 with every frame.
    assign launch     = ~act_q & full_q[nptr_q];

    assign pitch32 = 32'(pitch_q);
    assign pblk32  = pitch32 << BSH;
    assign blkw32  = 32'(BLK_W);

    always_comb begin
        addr_d = addr_q + 32'd4;
        row_d  = row_q;
        borg_d = borg_q;
        yorg_d = yorg_q;
        bx_d   = bx_q;
        by_d   = by_q;
        if (col_last) begin
            if (!blk_last) begin
                row_d  = row_q + pitch32;
                addr_d = row_d;
            end else if (bx_q != endx_q) begin
                bx_d   = bx_q + BLKCNT_W'(1);
                borg_d = borg_q + blkw32;
                row_d  = borg_d;
                addr_d = borg_d;
            end else begin
                bx_d   = '0;
                by_d   = by_q + BLKCNT_W'(1);
                yorg_d = yorg_q + pblk32;
                borg_d = yorg_d;
                row_d  = yorg_d;
                addr_d = yorg_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            pitch_q <= '0;
            endx_q  <= '0;
            endy_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            yorg_q  <= '0;
            borg_q  <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            widx_q  <= '0;
            cyc_q   <= 1'b0;
            fill_q  <= 1'b0;
            auto_q  <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            fend_q  <= 1'b0;
            act_q   <= 1'b0;
            start_q <= 1'b0;
            dbank_q <= 1'b0;
            nptr_q  <= 1'b0;
            full_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            if (reg_wr) begin
                case (sel)
                    3'd0:    src_q   <= wb_dat_i;
                    3'd1:    pitch_q <= wb_dat_i[PITCH_W-1:0];
                    3'd2:    endx_q  <= wb_dat_i[BLKCNT_W-1:0];
                    3'd3:    endy_q  <= wb_dat_i[BLKCNT_W-1:0];
                    3'd4:    auto_q  <= wb_dat_i[2];
                    default: ;
                endcase
            end

            if (((state_q != S_IDLE) || act_q) && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;

            start_q <= 1'b0;
            if (dct_done) begin
                act_q           <= 1'b0;
                full_q[dbank_q] <= 1'b0;
            end
            if (launch) begin
                start_q <= 1'b1;
                dbank_q <= nptr_q;
                nptr_q  <= ~nptr_q;
                act_q   <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (c_start) begin
                        error_q <= 1'b0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        full_q  <= 2'b00;
                        fill_q  <= 1'b0;
                        nptr_q  <= 1'b0;
                        widx_q  <= '0;
                        bx_q    <= '0;
                        by_q    <= '0;
                        yorg_q  <= src_q;
                        borg_q  <= src_q;
                        row_q   <= src_q;
                        addr_q  <= src_q;
                        fend_q  <= 1'b0;
                        cyc_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ack_ok) begin
                        widx_q <= widx_q + WI_W'(1);
                        addr_q <= addr_d;
                        row_q  <= row_d;
                        borg_q <= borg_d;
                        yorg_q <= yorg_d;
                        bx_q   <= bx_d;
                        by_q   <= by_d;
                        if (blk_last) begin
                            full_q[fill_q] <= 1'b1;
                            cyc_q          <= 1'b0;
                            fend_q         <= frame_last;
                            state_q        <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (fend_q) begin
                        state_q <= S_FLUSH;
                    end else if (!auto_q) begin
                        state_q <= S_WAITNEXT;
                    end else begin
                        fill_q <= other_bank;
                        if (bank_free[other_bank]) begin
                            cyc_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_WAITBANK;
                        end
                    end
                end
                S_WAITNEXT: begin
                    if (c_next && !auto_q) begin
                        fill_q <= other_bank;
                        if (bank_free[other_bank]) begin
                            cyc_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_WAITBANK;
                        end
                    end
                end
                S_WAITBANK: begin
                    if (bank_free[fill_q]) begin
                        cyc_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if ((full_q == 2'b00) && !act_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Abort and bus error tear everything down, including a launch
            // that would otherwise fire this cycle.
            if (c_abort || bus_err) begin
                state_q <= S_IDLE;
                cyc_q   <= 1'b0;
                full_q  <= 2'b00;
                act_q   <= 1'b0;
                start_q <= 1'b0;
                error_q <= error_q | bus_err;
            end
        end
    end

    logic dct_ready, running;
    assign running   = (state_q != S_IDLE);
    assign dct_ready = ~auto_q & (state_q == S_WAITNEXT) & ~act_q;

    always_comb begin
        wb_dat_o = '0;
        case (sel)
            3'd0: wb_dat_o = src_q;
            3'd1: wb_dat_o = 32'(pitch_q);
            3'd2: wb_dat_o = 32'(endx_q);
            3'd3: wb_dat_o = 32'(endy_q);
            3'd4: wb_dat_o = {cnt_q, 8'(by_q), 2'b00, done_q, error_q, auto_q,
                              |full_q, dct_ready, running};
            default: wb_dat_o = '0;
        endcase
    end

    assign wbm_adr_o   = addr_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hF;
    assign bram_data_o = wbm_dat_i;
    assign bram_addr_o = {fill_q, widx_q};
    assign bram_we_o   = ack_ok;
    assign start_dct_o = start_q;
    assign dct_bank_o  = dbank_q;
endmodule

// File: tb/tb_jpeg_dma_pp.sv
// Testbench for jpeg_dma_pp: directed frames against a behavioural
// address/bank model, with a wait-state Wishbone slave and a DCT responder.
module tb_jpeg_dma_pp;
    localparam int BLK_W = 8;
    localparam int WPB   = BLK_W * BLK_W / 4;
    localparam int BA_W  = $clog2(WPB) + 1;

    logic            clk_i, rst_i, dmaen_i, wb_we_i;
    logic [31:0]     wb_adr_i, wb_dat_i, wb_dat_o;
    logic [31:0]     wbm_adr_o, wbm_dat_i;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
    logic [3:0]      wbm_sel_o;
    logic [31:0]     bram_data_o;
    logic [BA_W-1:0] bram_addr_o;
    logic            bram_we_o, start_dct_o, dct_bank_o, dct_busy_i;

    jpeg_dma_pp #(.BLK_W(BLK_W), .PITCH_W(16), .BLKCNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dmaen_i(dmaen_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i), .wb_dat_o(wb_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .bram_data_o(bram_data_o),
        .bram_addr_o(bram_addr_o), .bram_we_o(bram_we_o), .start_dct_o(start_dct_o),
        .dct_bank_o(dct_bank_o), .dct_busy_i(dct_busy_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h00FF_1200;
    endfunction

    // Expected stream, built from the raster addressing formula.
    logic [31:0]     exp_addr[$];
    logic [BA_W-1:0] exp_ba[$];
    logic            exp_bank[$];
    int              n_writes, n_starts;
    bit              overlap_seen;
    time             t_w32, t_first_fall;
    logic [31:0]     cap_addr [0:255];

    task automatic clear_expect();
        exp_addr.delete();
        exp_ba.delete();
        exp_bank.delete();
    endtask

    task automatic build_expect(input int src, input int pitch, input int ex, input int ey);
        int k;
        logic bank;
        clear_expect();
        k = 0;
        for (int by = 0; by <= ey; by++) begin
            for (int bx = 0; bx <= ex; bx++) begin
                bank = (k % 2) == 1;
                exp_bank.push_back(bank);
                for (int r = 0; r < BLK_W; r++) begin
                    for (int c = 0; c < BLK_W / 4; c++) begin
                        exp_addr.push_back(32'(src + by * BLK_W * pitch + bx * BLK_W + r * pitch + c * 4));
                        exp_ba.push_back(BA_W'(int'(bank) * WPB + r * (BLK_W / 4) + c));
                    end
                end
                k++;
            end
        end
    endtask

    // Wishbone slave: ack after slv_wait idle cycles; err replaces the
    // slv_errw-th response.
    int slv_wait = 0, slv_errw = 0, slv_words = 0, slv_cnt = 0;
    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(negedge clk_i);
            if (wbm_ack_i || wbm_err_i) begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                slv_cnt   = 0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (slv_cnt >= slv_wait) begin
                    slv_cnt = 0;
                    slv_words++;
                    wbm_dat_i = memfn(wbm_adr_o);
                    if (slv_words == slv_errw) wbm_err_i = 1'b1;
                    else                       wbm_ack_i = 1'b1;
                end else begin
                    slv_cnt++;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // DCT responder: busy for dct_len cycles after each start pulse.
    int   dct_len = 10, dct_rem = 0, n_falls = 0;
    bit   dct_reading = 0;
    logic dct_rbank = 1'b0;
    initial begin
        dct_busy_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (start_dct_o) begin
                dct_busy_i  = 1'b1;
                dct_rem     = dct_len;
                dct_reading = 1'b1;
                dct_rbank   = dct_bank_o;
            end else if (dct_busy_i) begin
                dct_rem--;
                if (dct_rem <= 0) begin
                    dct_busy_i  = 1'b0;
                    dct_reading = 1'b0;
                    n_falls++;
                    if (n_falls == 1) t_first_fall = $time;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    bit prev_start = 1'b0;
    initial begin
        logic [31:0]     ea;
        logic [BA_W-1:0] eb;
        logic            ebank;
        forever begin
            @(negedge clk_i);
            #2;
            if (wbm_cyc_o || wbm_stb_o) begin
                check("stb_follows_cyc", {31'b0, wbm_stb_o}, {31'b0, wbm_cyc_o});
                check("master_we_sel", {27'b0, wbm_we_o, wbm_sel_o}, 32'h0000_000F);
            end
            if (bram_we_o) begin
                if (n_writes < 256) cap_addr[n_writes] = wbm_adr_o;
                if (n_writes == 32) t_w32 = $time;
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_bram_write: got bram_addr 0x%0h at rd addr 0x%08h, expected no write",
                             bram_addr_o, wbm_adr_o);
                end else begin
                    ea = exp_addr.pop_front();
                    eb = exp_ba.pop_front();
                    check("rd_addr", wbm_adr_o, ea);
                    check("bram_addr", 32'(bram_addr_o), 32'(eb));
                    check("bram_data", bram_data_o, memfn(wbm_adr_o));
                end
                if (dct_reading) begin
                    overlap_seen = 1'b1;
                    check("bank_conflict", {31'b0, bram_addr_o[BA_W-1] ^ dct_rbank}, 32'd1);
                end
                n_writes++;
            end
            if (start_dct_o) begin
                check("start_one_cycle", {31'b0, prev_start}, 32'd0);
                if (exp_bank.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start_dct: got start with bank %0d, expected none", dct_bank_o);
                end else begin
                    ebank = exp_bank.pop_front();
                    check("dct_bank", {31'b0, dct_bank_o}, {31'b0, ebank});
                end
                n_starts++;
            end
            prev_start = start_dct_o;
        end
    end

    task automatic wr_reg(input int sel, input logic [31:0] d);
        @(negedge clk_i);
        dmaen_i  = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'(sel * 4);
        wb_dat_i = d;
        @(negedge clk_i);
        dmaen_i  = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h10;
        wb_dat_i = '0;
    endtask

    task automatic rd_reg(input int sel, output logic [31:0] d);
        @(negedge clk_i);
        wb_adr_i = 32'(sel * 4);
        #1;
        d = wb_dat_o;
        wb_adr_i = 32'h10;
    endtask

    task automatic wait_status(input string name, input logic [31:0] mask,
                               input logic [31:0] val, input int budget);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        s  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            #1;
            s = wb_dat_o;
            if ((s & mask) == val) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: timeout with status 0x%08h, expected (status & 0x%08h) == 0x%08h",
                     name, s, mask, val);
        end
    endtask

    task automatic setup(input int src, input int pitch, input int ex, input int ey,
                         input int dlen, input int wn, input int errw);
        for (int i = 0; i < 1000 && dct_busy_i; i++) @(negedge clk_i);
        wr_reg(0, 32'(src));
        wr_reg(1, 32'(pitch));
        wr_reg(2, 32'(ex));
        wr_reg(3, 32'(ey));
        build_expect(src, pitch, ex, ey);
        n_writes     = 0;
        n_starts     = 0;
        overlap_seen = 1'b0;
        n_falls      = 0;
        t_w32        = 0;
        t_first_fall = 0;
        dct_len      = dlen;
        slv_wait     = wn;
        slv_errw     = errw;
        slv_words    = 0;
    endtask

    logic [31:0] s;

    initial begin
        rst_i    = 1'b1;
        dmaen_i  = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h10;
        wb_dat_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        // Reset state
        check("rst_status", wb_dat_o, 32'h0);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("rst_bram_we", {31'b0, bram_we_o}, 32'd0);
        check("rst_bram_addr", 32'(bram_addr_o), 32'd0);
        check("rst_start_dct", {31'b0, start_dct_o}, 32'd0);
        check("rst_dct_bank", {31'b0, dct_bank_o}, 32'd0);
        rd_reg(0, s); check("rst_srcaddr", s, 32'h0);
        rd_reg(1, s); check("rst_pitch", s, 32'h0);

        // Single block, MANUAL
        setup(32'h1000, 16, 0, 0, 10, 0, 0);
        rd_reg(0, s); check("reg_srcaddr", s, 32'h1000);
        rd_reg(1, s); check("reg_pitch", s, 32'd16);
        rd_reg(5, s); check("reg5_zero", s, 32'h0);
        wr_reg(4, 32'h1);
        wait_status("t1_frame_done", 32'h21, 32'h20, 500);
        check("t1_writes", n_writes, 16);
        check("t1_starts", n_starts, 1);
        check("t1_dct_finished", {31'b0, dct_reading}, 32'd0);
        check("t1_addr0", cap_addr[0], 32'h1000);
        check("t1_addr1", cap_addr[1], 32'h1004);
        check("t1_addr2", cap_addr[2], 32'h1010);
        check("t1_addr15", cap_addr[15], 32'h1074);
        rd_reg(4, s);
        check("t1_no_error", s & 32'h10, 32'h0);
        check("t1_cnt_nonzero", {31'b0, s[31:16] != 16'h0}, 32'd1);

        // 2x2 blocks, AUTO, 40-cycle DCT
        setup(32'h1000, 16, 1, 1, 40, 0, 0);
        wr_reg(4, 32'h5);
        wait_status("t2_frame_done", 32'h21, 32'h20, 3000);
        check("t2_writes", n_writes, 64);
        check("t2_starts", n_starts, 4);
        check("t2_origin1", cap_addr[16], 32'h1008);
        check("t2_origin2", cap_addr[32], 32'h1080);
        check("t2_origin3", cap_addr[48], 32'h1088);
        check("t2_overlap", {31'b0, overlap_seen}, 32'd1);
        rd_reg(4, s);
        check("t2_auto_bit", s & 32'h8, 32'h8);

        // AUTO, slow DCT: third block waits for the first DCT to finish
        setup(32'h2000, 32, 1, 1, 200, 0, 0);
        wr_reg(4, 32'h5);
        wait_status("t3_frame_done", 32'h21, 32'h20, 5000);
        check("t3_writes", n_writes, 64);
        check("t3_starts", n_starts, 4);
        check("t3_origin2", cap_addr[32], 32'h2100);
        check("t3_stall", {31'b0, (t_first_fall != 0) && (t_w32 > t_first_fall)}, 32'd1);

        // MANUAL, 2 blocks
        setup(32'h1000, 16, 1, 0, 10, 0, 0);
        wr_reg(4, 32'h1);
        wait_status("t4_waitnext", 32'h03, 32'h03, 500);
        check("t4_writes_first", n_writes, 16);
        repeat (20) @(negedge clk_i);
        check("t4_holds", n_writes, 16);
        wr_reg(4, 32'h2);
        wait_status("t4_frame_done", 32'h21, 32'h20, 1000);
        check("t4_writes", n_writes, 32);
        check("t4_starts", n_starts, 2);
        check("t4_origin1", cap_addr[16], 32'h1008);

        // Wait-stated slave, bus error on the 7th word
        setup(32'h1000, 16, 0, 0, 10, 2, 7);
        wr_reg(4, 32'h5);
        wait_status("t5_error", 32'h11, 32'h10, 1000);
        check("t5_writes", n_writes, 6);
        check("t5_starts", n_starts, 0);
        check("t5_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        clear_expect();
        repeat (10) @(negedge clk_i);
        check("t5_no_more_writes", n_writes, 6);

        // Abort during FETCH, then a fresh frame
        setup(32'h1000, 16, 0, 0, 10, 0, 0);
        wr_reg(4, 32'h5);
        for (int i = 0; i < 500 && n_writes < 5; i++) @(negedge clk_i);
        wr_reg(4, 32'h8);
        #1;
        check("t6_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("t6_running", wb_dat_o & 32'h1, 32'h0);
        clear_expect();
        repeat (20) @(negedge clk_i);
        check("t6_starts", n_starts, 0);
        rd_reg(4, s);
        check("t6_no_error", s & 32'h10, 32'h0);
        setup(32'h1000, 16, 0, 0, 10, 0, 0);
        wr_reg(4, 32'h5);
        wait_status("t6_frame_done", 32'h21, 32'h20, 500);
        check("t6_writes", n_writes, 16);
        check("t6_addr0", cap_addr[0], 32'h1000);

        // rst_i during FLUSH, then a fresh frame
        setup(32'h1000, 16, 0, 0, 60, 0, 0);
        wr_reg(4, 32'h5);
        for (int i = 0; i < 500 && n_starts < 1; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        #1;
        check("t7_in_flush", wb_dat_o & 32'h1, 32'h1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("t7_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("t7_status", wb_dat_o, 32'h0);
        clear_expect();
        repeat (20) @(negedge clk_i);
        check("t7_starts", n_starts, 1);
        rd_reg(0, s); check("t7_src_reset", s, 32'h0);
        setup(32'h1000, 16, 0, 0, 10, 0, 0);
        wr_reg(4, 32'h5);
        wait_status("t7_frame_done", 32'h21, 32'h20, 500);
        check("t7_writes", n_writes, 16);
        check("t7_starts_fresh", n_starts, 1);
        check("t7_addr0", cap_addr[0], 32'h1000);

        repeat (5) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
